// File: rtl/commit_merge_unit_pkg.sv
// Shared types and sizing for the commit merge unit: per-thread widths, packet bound,
// header layout and FSM state encoding.
package commit_merge_unit_pkg;

  localparam int unsigned NUM_THREADS = 4;
  localparam int unsigned NUM_LANES   = 1;
  localparam int unsigned XLEN        = 32;
  localparam int unsigned UUID_WIDTH  = 44;
  localparam int unsigned NW_WIDTH    = 2;
  localparam int unsigned PC_BITS     = 30;
  localparam int unsigned NR_BITS     = 6;

  localparam int unsigned NUM_PKTS = NUM_THREADS / NUM_LANES;
  localparam int unsigned CNT_W    = $clog2(NUM_PKTS) + 1;
  localparam int unsigned DATA_W   = NUM_THREADS * XLEN;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  // Per-instruction header, taken from the sop packet of a sequence
  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    pc;
    logic                  wb;
    logic [NR_BITS-1:0]    rd;
  } hdr_t;

  function automatic logic at_pkt_limit(input logic [CNT_W-1:0] n);
    return n == CNT_W'(NUM_PKTS);
  endfunction

endpackage

// File: rtl/commit_merge_lanes.sv
// Masked lane merge: folds one expanded packet into the accumulated tmask/data and
// flags lanes written twice within a sequence.
module commit_merge_lanes
  import commit_merge_unit_pkg::*;
(
  input  logic [NUM_THREADS-1:0] acc_tmask_i,
  input  logic [DATA_W-1:0]      acc_data_i,
  input  logic [NUM_THREADS-1:0] pkt_tmask_i,
  input  logic [DATA_W-1:0]      pkt_data_i,
  output logic [NUM_THREADS-1:0] mrg_tmask_o,
  output logic [DATA_W-1:0]      mrg_data_o,
  output logic                   overlap_o
);

  always_comb begin
    mrg_tmask_o = acc_tmask_i | pkt_tmask_i;
    mrg_data_o  = acc_data_i;
    for (int j = 0; j < int'(NUM_THREADS); j++) begin
      if (pkt_tmask_i[j]) begin
        mrg_data_o[j*XLEN +: XLEN] = pkt_data_i[j*XLEN +: XLEN];
      end
    end
  end

  assign overlap_o = |(acc_tmask_i & pkt_tmask_i);

endmodule

// File: rtl/commit_merge_unit.sv
// Merges sop..eop sequences of expanded commit packets into one registered full-warp
// commit; a sticky err flags protocol violations until reset.
module commit_merge_unit
  import commit_merge_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [UUID_WIDTH-1:0]  in_uuid,
  input  logic [NW_WIDTH-1:0]    in_wid,
  input  logic [NUM_THREADS-1:0] in_tmask,
  input  logic [PC_BITS-1:0]     in_PC,
  input  logic                   in_wb,
  input  logic [NR_BITS-1:0]     in_rd,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_sop,
  input  logic                   in_eop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [UUID_WIDTH-1:0]  out_uuid,
  output logic [NW_WIDTH-1:0]    out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [PC_BITS-1:0]     out_PC,
  output logic                   out_wb,
  output logic [NR_BITS-1:0]     out_rd,
  output logic [DATA_W-1:0]      out_data,
  output logic [CNT_W-1:0]       out_npkts,
  output logic                   err
);

  state_e                 state_q, state_d;
  hdr_t                   acc_hdr_q, acc_hdr_d;
  logic [NUM_THREADS-1:0] acc_tmask_q, acc_tmask_d;
  logic [DATA_W-1:0]      acc_data_q, acc_data_d;
  logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;

  logic                   out_valid_q, out_valid_d;
  hdr_t                   out_hdr_q, out_hdr_d;
  logic [NUM_THREADS-1:0] out_tmask_q, out_tmask_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0]       out_npkts_q, out_npkts_d;
  logic                   err_q, err_d;

  hdr_t                   in_hdr;
  logic                   accept;
  logic                   fire;
  logic                   start_new;
  logic [CNT_W-1:0]       cnt_inc;
  logic [NUM_THREADS-1:0] mrg_tmask;
  logic [DATA_W-1:0]      mrg_data;
  logic                   overlap;

  always_comb begin
    in_hdr.uuid = in_uuid;
    in_hdr.wid  = in_wid;
    in_hdr.pc   = in_PC;
    in_hdr.wb   = in_wb;
    in_hdr.rd   = in_rd;
  end

  // A held commit blocks new input unless it leaves this cycle
  assign in_ready = (state_q == ST_HOLD) ? out_ready : 1'b1;
  assign accept   = in_valid & in_ready;
  assign fire     = out_valid_q & out_ready;
  assign cnt_inc  = acc_cnt_q + CNT_W'(1);

  commit_merge_lanes u_lanes (
    .acc_tmask_i (acc_tmask_q),
    .acc_data_i  (acc_data_q),
    .pkt_tmask_i (in_tmask),
    .pkt_data_i  (in_data),
    .mrg_tmask_o (mrg_tmask),
    .mrg_data_o  (mrg_data),
    .overlap_o   (overlap)
  );

  // Next-state and next-output computation
  always_comb begin
    state_d     = state_q;
    acc_hdr_d   = acc_hdr_q;
    acc_tmask_d = acc_tmask_q;
    acc_data_d  = acc_data_q;
    acc_cnt_d   = acc_cnt_q;
    out_valid_d = out_valid_q;
    out_hdr_d   = out_hdr_q;
    out_tmask_d = out_tmask_q;
    out_data_d  = out_data_q;
    out_npkts_d = out_npkts_q;
    err_d       = err_q;
    start_new   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        start_new = accept;
      end
      ST_ACCUM: begin
        if (accept) begin
          if (in_sop) begin
            err_d     = 1'b1;
            start_new = 1'b1;
          end else begin
            if ((in_wid != acc_hdr_q.wid) || overlap) begin
              err_d = 1'b1;
            end
            if (in_eop || at_pkt_limit(cnt_inc)) begin
              if (!in_eop) begin
                err_d = 1'b1;
              end
              out_valid_d = 1'b1;
              out_hdr_d   = acc_hdr_q;
              out_tmask_d = mrg_tmask;
              out_data_d  = mrg_data;
              out_npkts_d = cnt_inc;
              state_d     = ST_HOLD;
            end else begin
              acc_tmask_d = mrg_tmask;
              acc_data_d  = mrg_data;
              acc_cnt_d   = cnt_inc;
            end
          end
        end
      end
      ST_HOLD: begin
        if (fire) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          start_new   = accept;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Packet that opens a sequence, handled identically from every state
    if (start_new) begin
      if (!in_sop) begin
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end else if (in_eop) begin
        out_valid_d = 1'b1;
        out_hdr_d   = in_hdr;
        out_tmask_d = in_tmask;
        out_data_d  = in_data;
        out_npkts_d = CNT_W'(1);
        state_d     = ST_HOLD;
      end else begin
        acc_hdr_d   = in_hdr;
        acc_tmask_d = in_tmask;
        acc_data_d  = in_data;
        acc_cnt_d   = CNT_W'(1);
        state_d     = ST_ACCUM;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      acc_hdr_q   <= '0;
      acc_tmask_q <= '0;
      acc_data_q  <= '0;
      acc_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_hdr_q   <= '0;
      out_tmask_q <= '0;
      out_data_q  <= '0;
      out_npkts_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_hdr_q   <= acc_hdr_d;
      acc_tmask_q <= acc_tmask_d;
      acc_data_q  <= acc_data_d;
      acc_cnt_q   <= acc_cnt_d;
      out_valid_q <= out_valid_d;
      out_hdr_q   <= out_hdr_d;
      out_tmask_q <= out_tmask_d;
      out_data_q  <= out_data_d;
      out_npkts_q <= out_npkts_d;
      err_q       <= err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_uuid  = out_hdr_q.uuid;
  assign out_wid   = out_hdr_q.wid;
  assign out_PC    = out_hdr_q.pc;
  assign out_wb    = out_hdr_q.wb;
  assign out_rd    = out_hdr_q.rd;
  assign out_tmask = out_tmask_q;
  assign out_data  = out_data_q;
  assign out_npkts = out_npkts_q;
  assign err       = err_q;

endmodule

// File: tb/tb_commit_merge_unit.sv
// Bench for commit_merge_unit: directed protocol scenarios plus random traffic, all
// checked against a sequence-level reference model.
module tb_commit_merge_unit;
  import commit_merge_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   in_valid;
  logic                   in_ready;
  logic [UUID_WIDTH-1:0]  in_uuid;
  logic [NW_WIDTH-1:0]    in_wid;
  logic [NUM_THREADS-1:0] in_tmask;
  logic [PC_BITS-1:0]     in_PC;
  logic                   in_wb;
  logic [NR_BITS-1:0]     in_rd;
  logic [DATA_W-1:0]      in_data;
  logic                   in_sop;
  logic                   in_eop;
  logic                   out_valid;
  logic                   out_ready;
  logic [UUID_WIDTH-1:0]  out_uuid;
  logic [NW_WIDTH-1:0]    out_wid;
  logic [NUM_THREADS-1:0] out_tmask;
  logic [PC_BITS-1:0]     out_PC;
  logic                   out_wb;
  logic [NR_BITS-1:0]     out_rd;
  logic [DATA_W-1:0]      out_data;
  logic [CNT_W-1:0]       out_npkts;
  logic                   err;

  always #5 clk = ~clk;

  commit_merge_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
    .in_tmask(in_tmask), .in_PC(in_PC), .in_wb(in_wb), .in_rd(in_rd),
    .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop),
    .out_valid(out_valid), .out_ready(out_ready), .out_uuid(out_uuid),
    .out_wid(out_wid), .out_tmask(out_tmask), .out_PC(out_PC), .out_wb(out_wb),
    .out_rd(out_rd), .out_data(out_data), .out_npkts(out_npkts), .err(err)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one open sequence and at most one pending commit
  bit                    m_open;
  logic [UUID_WIDTH-1:0] m_uuid;
  logic [NW_WIDTH-1:0]   m_wid;
  logic [PC_BITS-1:0]    m_pc;
  logic                  m_wb;
  logic [NR_BITS-1:0]    m_rd;
  logic [3:0]            m_tm;
  logic [31:0]           m_lane [4];
  int                    m_cnt;

  bit                    e_valid;
  logic [UUID_WIDTH-1:0] e_uuid;
  logic [NW_WIDTH-1:0]   e_wid;
  logic [PC_BITS-1:0]    e_pc;
  logic                  e_wb;
  logic [NR_BITS-1:0]    e_rd;
  logic [3:0]            e_tm;
  logic [31:0]           e_lane [4];
  int                    e_npkts;
  bit                    e_err;

  task automatic model_reset();
    m_open = 0; m_cnt = 0;
    e_valid = 0; e_err = 0; e_npkts = 0; e_tm = '0;
    e_uuid = '0; e_wid = '0; e_pc = '0; e_wb = 1'b0; e_rd = '0;
    for (int j = 0; j < 4; j++) e_lane[j] = '0;
  endtask

  task automatic emit();
    e_valid = 1; e_uuid = m_uuid; e_wid = m_wid; e_pc = m_pc; e_wb = m_wb; e_rd = m_rd;
    e_tm = m_tm; e_npkts = m_cnt;
    for (int j = 0; j < 4; j++) e_lane[j] = m_lane[j];
    m_open = 0;
  endtask

  task automatic model_step();
    bit rdy;
    rdy = !e_valid || out_ready;
    if (e_valid && out_ready) e_valid = 0;
    if (in_valid && rdy) begin
      if (in_sop) begin
        if (m_open) e_err = 1;
        m_open = 1; m_uuid = in_uuid; m_wid = in_wid; m_pc = in_PC; m_wb = in_wb; m_rd = in_rd;
        m_tm = in_tmask; m_cnt = 1;
        for (int j = 0; j < 4; j++) m_lane[j] = in_data[j*32 +: 32];
        if (in_eop) emit();
      end else if (!m_open) begin
        e_err = 1;
      end else begin
        if (in_wid != m_wid) e_err = 1;
        if ((m_tm & in_tmask) != 4'b0) e_err = 1;
        m_tm = m_tm | in_tmask;
        for (int j = 0; j < 4; j++) if (in_tmask[j]) m_lane[j] = in_data[j*32 +: 32];
        m_cnt++;
        if (in_eop) emit();
        else if (m_cnt == int'(NUM_PKTS)) begin
          e_err = 1;
          emit();
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [127:0] d;
    for (int j = 0; j < 4; j++) d[j*32 +: 32] = e_lane[j];
    chk_val("out_valid", 128'(out_valid), 128'(e_valid));
    chk_val("err", 128'(err), 128'(e_err));
    if (e_valid) begin
      chk_val("out_uuid", 128'(out_uuid), 128'(e_uuid));
      chk_val("out_wid", 128'(out_wid), 128'(e_wid));
      chk_val("out_PC", 128'(out_PC), 128'(e_pc));
      chk_val("out_wb", 128'(out_wb), 128'(e_wb));
      chk_val("out_rd", 128'(out_rd), 128'(e_rd));
      chk_val("out_tmask", 128'(out_tmask), 128'(e_tm));
      chk_val("out_data", 128'(out_data), d);
      chk_val("out_npkts", 128'(out_npkts), 128'(e_npkts));
    end
  endtask

  // One clock of stimulus, started at a falling edge; header fields are randomised
  task automatic cycle(input bit v, input bit sop, input bit eop, input logic [3:0] tm,
                       input logic [127:0] data, input logic [1:0] wid, input bit ordy);
    in_valid = v; in_sop = sop; in_eop = eop; in_tmask = tm; in_data = data; in_wid = wid;
    in_uuid = 44'({$urandom(), $urandom()}); in_PC = 30'($urandom());
    in_wb = 1'($urandom()); in_rd = 6'($urandom());
    out_ready = ordy;
    #1;
    chk_val("in_ready", 128'(in_ready), 128'(!e_valid || ordy));
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Async reset asserted between clock edges, checked before any edge arrives
  task automatic do_reset();
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk_val("rst_out_valid", 128'(out_valid), 128'(0));
    chk_val("rst_err", 128'(err), 128'(0));
    chk_val("rst_npkts", 128'(out_npkts), 128'(0));
    chk_val("rst_tmask", 128'(out_tmask), 128'(0));
    chk_val("rst_data", 128'(out_data), 128'(0));
    chk_val("rst_uuid", 128'(out_uuid), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  function automatic logic [127:0] pk(input logic [31:0] a3, input logic [31:0] a2,
                                      input logic [31:0] a1, input logic [31:0] a0);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [UUID_WIDTH-1:0] t2_uuid;
  logic [1:0]            cur_wid;

  initial begin
    reset = 1'b0; in_valid = 0; in_sop = 0; in_eop = 0; in_tmask = '0; in_data = '0;
    in_wid = '0; in_uuid = '0; in_PC = '0; in_wb = 0; in_rd = '0; out_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_val("init_out_valid", 128'(out_valid), 128'(0));
    chk_val("init_err", 128'(err), 128'(0));
    chk_val("init_npkts", 128'(out_npkts), 128'(0));
    reset = 1'b1;

    // Single full-warp packets, one per cycle
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 4'hF, pk(4, 3, 2, 1), 2'd1, 1);
    chk_val("t1_data", 128'(out_data), pk(4, 3, 2, 1));
    chk_val("t1_npkts", 128'(out_npkts), 128'(1));
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);

    // Four single-lane packets merged into one commit
    cycle(1, 1, 0, 4'b0001, {rnd_data()} & ~128'hFFFF_FFFF | 128'hA, 2'd2, 1);
    t2_uuid = in_uuid;
    cycle(1, 0, 0, 4'b0010, pk(0, 0, 32'hB, 0), 2'd2, 1);
    cycle(1, 0, 0, 4'b0100, pk(0, 32'hC, 0, 0), 2'd2, 1);
    cycle(1, 0, 1, 4'b1000, pk(32'hD, 0, 0, 0), 2'd2, 1);
    chk_val("t2_tmask", 128'(out_tmask), 128'hF);
    chk_val("t2_data", 128'(out_data), pk(32'hD, 32'hC, 32'hB, 32'hA));
    chk_val("t2_npkts", 128'(out_npkts), 128'(4));
    chk_val("t2_uuid", 128'(out_uuid), 128'(t2_uuid));
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);

    // Backpressure in HOLD, then fire and accept in the same cycle
    cycle(1, 1, 1, 4'hF, rnd_data(), 2'd0, 1);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 4'hF, pk(9, 9, 9, 9), 2'd3, 0);
    chk_val("t3_in_ready", 128'(in_ready), 128'(0));
    cycle(1, 1, 1, 4'hF, pk(8, 7, 6, 5), 2'd3, 1);
    chk_val("t3_next_valid", 128'(out_valid), 128'(1));
    chk_val("t3_next_data", 128'(out_data), pk(8, 7, 6, 5));
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);

    // Protocol errors, each from a clean reset
    do_reset();
    cycle(1, 0, 1, 4'hF, rnd_data(), 2'd0, 1);
    chk_val("t4a_err", 128'(err), 128'(1));
    chk_val("t4a_valid", 128'(out_valid), 128'(0));
    do_reset();
    cycle(1, 1, 0, 4'b0001, rnd_data(), 2'd0, 1);
    cycle(1, 1, 1, 4'b0010, rnd_data(), 2'd1, 1);
    chk_val("t4b_err", 128'(err), 128'(1));
    chk_val("t4b_npkts", 128'(out_npkts), 128'(1));
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);
    do_reset();
    cycle(1, 1, 0, 4'b0011, pk(0, 0, 32'h11, 32'h10), 2'd0, 1);
    cycle(1, 0, 1, 4'b0010, pk(0, 0, 32'h22, 0), 2'd0, 1);
    chk_val("t4c_err", 128'(err), 128'(1));
    chk_val("t4c_lane1", 128'(out_data[63:32]), 128'h22);

    // Sequence overrunning NUM_PKTS without eop
    do_reset();
    for (int i = 0; i < 5; i++)
      cycle(1, i == 0, 0, 4'(1 << (i % 4)), rnd_data(), 2'd1, 1);
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);
    do_reset();
    for (int i = 0; i < 4; i++)
      cycle(1, i == 0, 0, 4'(1 << i), rnd_data(), 2'd1, 0);
    chk_val("t5_valid", 128'(out_valid), 128'(1));
    chk_val("t5_npkts", 128'(out_npkts), 128'(4));
    chk_val("t5_err", 128'(err), 128'(1));
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);

    // Reset in the middle of an accumulation
    cycle(1, 1, 0, 4'b0001, rnd_data(), 2'd0, 1);
    cycle(1, 0, 0, 4'b0010, rnd_data(), 2'd0, 1);
    do_reset();
    cycle(1, 1, 1, 4'b0101, pk(1, 2, 3, 4), 2'd2, 1);
    chk_val("t6_npkts", 128'(out_npkts), 128'(1));
    chk_val("t6_tmask", 128'(out_tmask), 128'b0101);
    cycle(0, 0, 0, 4'h0, '0, 2'd0, 1);

    // Random traffic with periodic resets
    cur_wid = 2'd0;
    for (int i = 0; i < 800; i++) begin
      bit v, s, e, r;
      logic [1:0] w;
      if (i % 97 == 96) do_reset();
      v = ($urandom_range(0, 9) < 8);
      s = ($urandom_range(0, 3) == 0);
      e = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 3) != 0);
      if (s) cur_wid = 2'($urandom());
      w = ($urandom_range(0, 7) == 0) ? 2'($urandom()) : cur_wid;
      cycle(v, s, e, 4'($urandom()), rnd_data(), w, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
